// File: rtl/mem_perf_monitor_pkg.sv
// Shared types and constants for the memory performance monitor.
// The default counter widths match the perf interface counters in the core.
package mem_perf_monitor_pkg;

  localparam int MEM_PERF_CTR_BITS  = 44;
  localparam int MEM_PERF_PEND_BITS = 16;

  typedef struct packed {
    logic [MEM_PERF_CTR_BITS-1:0]  loads;
    logic [MEM_PERF_CTR_BITS-1:0]  stores;
    logic [MEM_PERF_CTR_BITS-1:0]  latency;
    logic [MEM_PERF_PEND_BITS-1:0] pending;
  } mem_perf_cnt_t;

  // Population count of up to 32 channels; callers zero-extend narrower vectors.
  function automatic logic [5:0] popcount32(input logic [31:0] vec);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mem_perf_monitor_if.sv
// Request/response handshake bundle of one observed memory bus.
// The monitor connects through the slave modport and only ever samples it.
interface mem_perf_monitor_if #(
  parameter int NUM_REQS = 4
) ();

  logic [NUM_REQS-1:0] req_valid;
  logic [NUM_REQS-1:0] req_ready;
  logic [NUM_REQS-1:0] req_rw;
  logic [NUM_REQS-1:0] rsp_valid;
  logic [NUM_REQS-1:0] rsp_ready;

  modport master (
    output req_valid, req_ready, req_rw, rsp_valid, rsp_ready
  );

  modport slave (
    input req_valid, req_ready, req_rw, rsp_valid, rsp_ready
  );

endinterface

// File: rtl/mem_perf_monitor_fire_reg.sv
// Stage-1 capture of the read, write and response fire vectors.
// Only reset clears it, so in-flight fires survive a statistics clear.
module mem_perf_fire_reg #(
  parameter int NUM_REQS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] rd_fire,
  input  logic [NUM_REQS-1:0] wr_fire,
  input  logic [NUM_REQS-1:0] rsp_fire,
  output logic [NUM_REQS-1:0] rd_fire_reg,
  output logic [NUM_REQS-1:0] wr_fire_reg,
  output logic [NUM_REQS-1:0] rsp_fire_reg
);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_fire_reg  <= '0;
      wr_fire_reg  <= '0;
      rsp_fire_reg <= '0;
    end else begin
      rd_fire_reg  <= rd_fire;
      wr_fire_reg  <= wr_fire;
      rsp_fire_reg <= rsp_fire;
    end
  end

endmodule

// File: rtl/mem_perf_monitor.sv
// Passive per-bus memory performance monitor: load/store counts, outstanding reads,
// accumulated read latency and sticky error flags. MEM_PERF_PEAK_EN adds peak_pending.
module mem_perf_monitor
  import mem_perf_monitor_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int CTR_BITS  = MEM_PERF_CTR_BITS,
  parameter int PEND_BITS = MEM_PERF_PEND_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  mem_perf_monitor_if.slave    bus,
  output logic [CTR_BITS-1:0]  loads,
  output logic [CTR_BITS-1:0]  stores,
  output logic [CTR_BITS-1:0]  latency,
  output logic [PEND_BITS-1:0] pending,
  output logic [PEND_BITS-1:0] peak_pending,
  output logic                 underflow,
  output logic                 overflow
);

  localparam int CW = $clog2(NUM_REQS + 1);
  localparam int PW = PEND_BITS + CW + 1;

  logic [NUM_REQS-1:0] rd_fire, wr_fire, rsp_fire;
  logic [NUM_REQS-1:0] rd_fire_reg, wr_fire_reg, rsp_fire_reg;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_fire
    assign rd_fire[gi]  = bus.req_valid[gi] & bus.req_ready[gi] & ~bus.req_rw[gi];
    assign wr_fire[gi]  = bus.req_valid[gi] & bus.req_ready[gi] &  bus.req_rw[gi];
    assign rsp_fire[gi] = bus.rsp_valid[gi] & bus.rsp_ready[gi];
  end

  mem_perf_fire_reg #(
    .NUM_REQS (NUM_REQS)
  ) fire_reg (
    .clk          (clk),
    .reset        (reset),
    .rd_fire      (rd_fire),
    .wr_fire      (wr_fire),
    .rsp_fire     (rsp_fire),
    .rd_fire_reg  (rd_fire_reg),
    .wr_fire_reg  (wr_fire_reg),
    .rsp_fire_reg (rsp_fire_reg)
  );

  logic [5:0] nr_full, nw_full, ns_full;
  logic [CW-1:0] nr, nw, ns;

  assign nr_full = popcount32(32'(rd_fire_reg));
  assign nw_full = popcount32(32'(wr_fire_reg));
  assign ns_full = popcount32(32'(rsp_fire_reg));
  assign nr = nr_full[CW-1:0];
  assign nw = nw_full[CW-1:0];
  assign ns = ns_full[CW-1:0];

  logic [CTR_BITS-1:0]  loads_reg, stores_reg, latency_reg;
  logic [PEND_BITS-1:0] pending_reg, pending_next;
  logic                 underflow_reg, overflow_reg;
  logic                 underflow_set, overflow_set;
  logic signed [PW-1:0] p_sum, p_max;

  // Wide signed sum so both out-of-range directions are visible before saturating.
  always_comb begin
    pending_next  = '0;
    underflow_set = 1'b0;
    overflow_set  = 1'b0;
    p_max = $signed({{(CW + 1){1'b0}}, {PEND_BITS{1'b1}}});
    p_sum = $signed({{(CW + 1){1'b0}}, pending_reg})
          + $signed({{(PEND_BITS + 1){1'b0}}, nr})
          - $signed({{(PEND_BITS + 1){1'b0}}, ns});
    if (p_sum < 0) begin
      underflow_set = 1'b1;
    end else if (p_sum > p_max) begin
      pending_next = {PEND_BITS{1'b1}};
      overflow_set = 1'b1;
    end else begin
      pending_next = p_sum[PEND_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loads_reg     <= '0;
      stores_reg    <= '0;
      latency_reg   <= '0;
      pending_reg   <= '0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (clear) begin
        loads_reg     <= '0;
        stores_reg    <= '0;
        latency_reg   <= '0;
        underflow_reg <= 1'b0;
        overflow_reg  <= 1'b0;
      end else begin
        loads_reg     <= loads_reg + CTR_BITS'(nr);
        stores_reg    <= stores_reg + CTR_BITS'(nw);
        latency_reg   <= latency_reg + CTR_BITS'(pending_reg);
        underflow_reg <= underflow_reg | underflow_set;
        overflow_reg  <= overflow_reg | overflow_set;
      end
    end
  end

`ifdef MEM_PERF_PEAK_EN
  logic [PEND_BITS-1:0] peak_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      peak_reg <= '0;
    end else if (pending_next > peak_reg) begin
      peak_reg <= pending_next;
    end
  end

  assign peak_pending = peak_reg;
`else
  assign peak_pending = '0;
`endif

  assign loads     = loads_reg;
  assign stores    = stores_reg;
  assign latency   = latency_reg;
  assign pending   = pending_reg;
  assign underflow = underflow_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mem_perf_monitor.sv
// Bench for mem_perf_monitor: a wide instance and a PEND_BITS=2 instance see the same
// traffic; an integer model is compared every cycle, plus directed literal checks.
module tb_mem_perf_monitor;
  import mem_perf_monitor_pkg::*;

  localparam int N = 4;
  localparam longint CMASK = (64'd1 << 44) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready = '0, req_rw = '0, rsp_valid = '0, rsp_ready = '0;

  always #5 clk = ~clk;

  mem_perf_monitor_if #(.NUM_REQS(N)) bus_a ();
  mem_perf_monitor_if #(.NUM_REQS(N)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_ready = req_ready;
  assign bus_a.req_rw    = req_rw;
  assign bus_a.rsp_valid = rsp_valid;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_ready = req_ready;
  assign bus_b.req_rw    = req_rw;
  assign bus_b.rsp_valid = rsp_valid;
  assign bus_b.rsp_ready = rsp_ready;

  logic [43:0] loads_a, stores_a, latency_a, loads_b, stores_b, latency_b;
  logic [15:0] pending_a, peak_a;
  logic [1:0]  pending_b, peak_b;
  logic        uf_a, of_a, uf_b, of_b;

  mem_perf_monitor #(.NUM_REQS(N), .CTR_BITS(44), .PEND_BITS(16)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus_a),
    .loads(loads_a), .stores(stores_a), .latency(latency_a), .pending(pending_a),
    .peak_pending(peak_a), .underflow(uf_a), .overflow(of_a)
  );

  mem_perf_monitor #(.NUM_REQS(N), .CTR_BITS(44), .PEND_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus_b),
    .loads(loads_b), .stores(stores_b), .latency(latency_b), .pending(pending_b),
    .peak_pending(peak_b), .underflow(uf_b), .overflow(of_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Integer model: fires become counts, applied to the statistics one cycle later.
  longint m_loads[2], m_stores[2], m_lat[2];
  int     m_pend[2], m_peak[2];
  bit     m_uf[2], m_of[2];
  int     d_r, d_w, d_s;
  int     pmax[2];
  initial begin
    pmax[0] = 65535;
    pmax[1] = 3;
  end

  always @(posedge clk) begin : model
    int cr, cw, cs, p, np;
    cr = $countones(req_valid & req_ready & ~req_rw);
    cw = $countones(req_valid & req_ready & req_rw);
    cs = $countones(rsp_valid & rsp_ready);
    if (reset) begin
      d_r <= 0; d_w <= 0; d_s <= 0;
      for (int k = 0; k < 2; k++) begin
        m_loads[k] <= 0; m_stores[k] <= 0; m_lat[k] <= 0;
        m_pend[k] <= 0; m_peak[k] <= 0; m_uf[k] <= 0; m_of[k] <= 0;
      end
    end else begin
      d_r <= cr; d_w <= cw; d_s <= cs;
      for (int k = 0; k < 2; k++) begin
        p  = m_pend[k] + d_r - d_s;
        np = (p < 0) ? 0 : (p > pmax[k]) ? pmax[k] : p;
        m_pend[k] <= np;
        if (clear) begin
          m_loads[k] <= 0; m_stores[k] <= 0; m_lat[k] <= 0;
          m_peak[k] <= 0; m_uf[k] <= 0; m_of[k] <= 0;
        end else begin
          m_loads[k]  <= (m_loads[k] + d_r) & CMASK;
          m_stores[k] <= (m_stores[k] + d_w) & CMASK;
          m_lat[k]    <= (m_lat[k] + m_pend[k]) & CMASK;
          m_peak[k]   <= (np > m_peak[k]) ? np : m_peak[k];
          if (p < 0) m_uf[k] <= 1;
          if (p > pmax[k]) m_of[k] <= 1;
        end
      end
    end
  end

  function automatic longint exp_peak(input int k);
`ifdef MEM_PERF_PEAK_EN
    return m_peak[k];
`else
    return 0;
`endif
  endfunction

  bit started = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("a_loads",   loads_a,   m_loads[0]);
      chk("a_stores",  stores_a,  m_stores[0]);
      chk("a_latency", latency_a, m_lat[0]);
      chk("a_pending", pending_a, m_pend[0]);
      chk("a_peak",    peak_a,    exp_peak(0));
      chk("a_uf",      uf_a,      m_uf[0]);
      chk("a_of",      of_a,      m_of[0]);
      chk("b_loads",   loads_b,   m_loads[1]);
      chk("b_stores",  stores_b,  m_stores[1]);
      chk("b_latency", latency_b, m_lat[1]);
      chk("b_pending", pending_b, m_pend[1]);
      chk("b_peak",    peak_b,    exp_peak(1));
      chk("b_uf",      uf_b,      m_uf[1]);
      chk("b_of",      of_b,      m_of[1]);
    end
  end

  int cyc_no = 0;

  // One bus cycle: stall channels show valid without ready on both request and response.
  task automatic cyc(input logic [N-1:0] rd, input logic [N-1:0] wr,
                     input logic [N-1:0] rsp, input logic [N-1:0] stall, input logic clr);
    req_valid = rd | wr | stall;
    req_ready = rd | wr;
    req_rw    = wr | (stall & 4'b1010);
    rsp_valid = rsp | stall;
    rsp_ready = rsp;
    clear     = clr;
    $display("cycle %0d rd=%b wr=%b rsp=%b stall=%b clear=%b", cyc_no, rd, wr, rsp, stall, clr);
    @(posedge clk);
    #1;
    req_valid = '0; req_ready = '0; req_rw = '0; rsp_valid = '0; rsp_ready = '0;
    clear = 1'b0;
    cyc_no++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc_no = 0;
  endtask

  initial begin
    do_reset();
    started = 1;
    chk("reset_loads", loads_a, 0);
    chk("reset_pending", pending_a, 0);
    chk("reset_uf", uf_b, 0);

    // Three reads on one cycle.
    cyc(4'b1011, '0, '0, 4'b0100, 1'b0);
    idle(1);
    chk("t1_loads_c2", loads_a, 3);
    chk("t1_pending_c2", pending_a, 3);
    chk("t1_latency_c2", latency_a, 0);
    idle(1);
    chk("t1_latency_c3", latency_a, 3);
    idle(1);
    chk("t1_latency_c4", latency_a, 6);

    // Writes over two cycles plus one read, then a single response.
    do_reset();
    cyc(4'b0100, 4'b0011, '0, '0, 1'b0);
    cyc('0, 4'b1100, '0, 4'b0011, 1'b0);
    idle(3);
    chk("t2_stores", stores_a, 4);
    chk("t2_loads", loads_a, 1);
    chk("t2_pending", pending_a, 1);
    cyc('0, '0, 4'b0001, '0, 1'b0);
    idle(1);
    chk("t2_pending_c7", pending_a, 0);
    chk("t2_latency_c7", latency_a, 5);
    idle(1);
    chk("t2_latency_c8", latency_a, 5);

    // Stray response, then clear.
    do_reset();
    cyc('0, '0, 4'b0010, '0, 1'b0);
    idle(1);
    chk("t3_pending", pending_a, 0);
    chk("t3_underflow", uf_a, 1);
    cyc('0, '0, '0, '0, 1'b1);
    chk("t3_uf_cleared", uf_a, 0);
    chk("t3_loads_cleared", loads_a, 0);

    // Five reads into a 2-bit outstanding counter.
    do_reset();
    cyc(4'b1111, '0, '0, '0, 1'b0);
    cyc(4'b0001, '0, '0, '0, 1'b0);
    idle(2);
    chk("t4_b_pending", pending_b, 3);
    chk("t4_b_overflow", of_b, 1);
    chk("t4_a_pending", pending_a, 5);
    chk("t4_a_overflow", of_a, 0);
`ifdef MEM_PERF_PEAK_EN
    chk("t4_b_peak", peak_b, 3);
`else
    chk("t4_b_peak", peak_b, 0);
`endif

    // Clear while reads are still in stage 1.
    do_reset();
    cyc(4'b0011, '0, '0, '0, 1'b0);
    cyc('0, '0, '0, '0, 1'b1);
    chk("t5_loads", loads_a, 0);
    chk("t5_latency", latency_a, 0);
    chk("t5_pending", pending_a, 2);
    chk("t5_peak", peak_a, 0);
    cyc('0, '0, 4'b0110, '0, 1'b0);
    idle(2);
    chk("t5_pending_end", pending_a, 0);
    chk("t5_no_uf", uf_a, 0);
    chk("t5_loads_end", loads_a, 0);

    // Reads and responses on the same cycle.
    do_reset();
    cyc(4'b0001, '0, '0, '0, 1'b0);
    idle(1);
    cyc(4'b0110, '0, 4'b1001, '0, 1'b0);
    idle(1);
    chk("t6_pending", pending_a, 1);
    chk("t6_loads", loads_a, 3);
    chk("t6_uf", uf_a, 0);
    chk("t6_of", of_a, 0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
